// File: rtl/boot_loader_if.sv
// Boot loader bus bundle: SPI flash pins plus the instruction memory write port.
interface boot_loader_if;
    logic        spi_sck;
    logic        spi_csn;
    logic        spi_mosi;
    logic        spi_miso;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;

    // Loader side: drives the flash pins and the memory write port.
    modport master (
        output spi_sck, spi_csn, spi_mosi, wr_en, wr_addr, wr_data,
        input  spi_miso
    );

    // Flash / memory side.
    modport slave (
        input  spi_sck, spi_csn, spi_mosi, wr_en, wr_addr, wr_data,
        output spi_miso
    );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: issues an SPI READ (0x03) to flash and copies WORDS 16-bit words
// into instruction memory, one write strobe per word.
module boot_loader #(
    parameter int unsigned WORDS      = 256,
    parameter logic [23:0] FLASH_ADDR = 24'h020000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    boot_loader_if.master bus
);

    localparam logic [7:0] LAST_ADDR = 8'(WORDS - 1);

    typedef enum logic [2:0] {StIdle, StCmd, StData, StWrite, StFin, StDone} state_e;

    state_e      state_q, state_d;
    // cnt_q counts clk cycles inside CMD/DATA; bit 0 is the SCK phase.
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] cmd_q, cmd_d;
    logic [15:0] shift_q, shift_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cmd_q   <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StCmd;
                    cnt_d   = '0;
                    cmd_d   = {8'h03, FLASH_ADDR};
                    addr_d  = '0;
                end
            end
            StCmd: begin
                cnt_d = cnt_q + 6'd1;
                // Shift on the edge that ends the high phase so MOSI moves while SCK is low.
                if (cnt_q[0]) begin
                    cmd_d = {cmd_q[30:0], 1'b0};
                end
                if (cnt_q == 6'd63) begin
                    state_d = StData;
                    cnt_d   = '0;
                end
            end
            StData: begin
                cnt_d = cnt_q + 6'd1;
                // Sample MISO on the edge that drives SCK high-to-low.
                if (cnt_q[0]) begin
                    shift_d = {shift_q[14:0], bus.spi_miso};
                end
                if (cnt_q == 6'd31) begin
                    state_d = StWrite;
                    data_d  = {shift_q[14:0], bus.spi_miso};
                end
            end
            StWrite: begin
                cnt_d   = '0;
                addr_d  = addr_q + 8'd1;
                state_d = (addr_q == LAST_ADDR) ? StFin : StData;
            end
            StFin: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state only, so reset reaches them without a clock.
    always_comb begin
        bus.spi_sck  = ((state_q == StCmd) || (state_q == StData)) && cnt_q[0];
        bus.spi_csn  = !((state_q == StCmd) || (state_q == StData) || (state_q == StWrite));
        bus.spi_mosi = (state_q == StCmd) && cmd_q[31];
        bus.wr_en    = (state_q == StWrite);
        bus.wr_addr  = addr_q;
        bus.wr_data  = data_q;
        busy         = (state_q == StCmd) || (state_q == StData) || (state_q == StWrite);
        done         = (state_q == StDone);
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a 4-word and a 256-word instance, each fed by
// a small SPI flash model.
module tb_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_b;
    logic busy_a, done_a, busy_b, done_b;

    boot_loader_if if_a ();
    boot_loader_if if_b ();

    boot_loader #(.WORDS(4), .FLASH_ADDR(24'h020000)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_a),
        .busy  (busy_a),
        .done  (done_a),
        .bus   (if_a.master)
    );

    boot_loader #(.WORDS(256), .FLASH_ADDR(24'h020000)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_b),
        .busy  (busy_b),
        .done  (done_b),
        .bus   (if_b.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [29:0] RST_VEC = {1'b1, 29'd0};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {csn, sck, mosi, wr_en, wr_addr, wr_data, busy, done}
    function automatic logic [29:0] obs_a();
        return {if_a.spi_csn, if_a.spi_sck, if_a.spi_mosi, if_a.wr_en, if_a.wr_addr,
                if_a.wr_data, busy_a, done_a};
    endfunction

    function automatic logic [29:0] obs_b();
        return {if_b.spi_csn, if_b.spi_sck, if_b.spi_mosi, if_b.wr_en, if_b.wr_addr,
                if_b.wr_data, busy_b, done_b};
    endfunction

    // Flash contents: fixed byte table for A, word k = {k, ~k} for B.
    logic [7:0] flash_a [8];

    function automatic logic fbit_a(input int k);
        logic [7:0] b;
        if (k >= 64) return 1'b0;
        b = flash_a[k / 8];
        return b[7 - (k % 8)];
    endfunction

    function automatic logic fbit_b(input int k);
        logic [15:0] v;
        v = {8'(k / 16), ~8'(k / 16)};
        return v[15 - (k % 16)];
    endfunction

    // Flash model A: capture 32 command bits on rising SCK, then shift data out on falling SCK.
    int rise_a = 0, dk_a = 0;
    logic [31:0] cmd_a = '0;
    always @(if_a.spi_sck or if_a.spi_csn) begin
        if (if_a.spi_csn !== 1'b0) begin
            rise_a = 0;
            dk_a   = 0;
            cmd_a  = '0;
            if_a.spi_miso <= 1'b0;
        end else if (if_a.spi_sck === 1'b1) begin
            if (rise_a < 32) cmd_a = {cmd_a[30:0], if_a.spi_mosi};
            rise_a++;
        end else if (rise_a >= 32) begin
            if_a.spi_miso <= fbit_a(dk_a);
            dk_a++;
        end
    end

    // Flash model B.
    int rise_b = 0, dk_b = 0;
    always @(if_b.spi_sck or if_b.spi_csn) begin
        if (if_b.spi_csn !== 1'b0) begin
            rise_b = 0;
            dk_b   = 0;
            if_b.spi_miso <= 1'b0;
        end else if (if_b.spi_sck === 1'b1) begin
            rise_b++;
        end else if (rise_b >= 32) begin
            if_b.spi_miso <= fbit_b(dk_b);
            dk_b++;
        end
    end

    int c, n_str, c_cmd, c_wr, c_done, csn_bad, err;
    logic [31:0] cmd_seen;
    logic [23:0] str_a [4];
    logic [23:0] exp_a [4];
    logic [7:0]  last_addr, first_addr;
    logic [15:0] exp16;

    initial begin
        flash_a = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFF};
        exp_a   = '{{8'd0, 16'h1234}, {8'd1, 16'hABCD}, {8'd2, 16'h0001}, {8'd3, 16'hFFFF}};
        str_a   = '{24'd0, 24'd0, 24'd0, 24'd0};
        cmd_seen = '0;
        start_a = 1'b0;
        start_b = 1'b0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("reset_a", obs_a(), RST_VEC);
        check_eq("reset_b", obs_b(), RST_VEC);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single start pulse, 4 words.
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        c = 0; n_str = 0; c_cmd = -1; c_wr = -1; c_done = -1; csn_bad = 0;
        while (c_done < 0 && c < 400) begin
            if (c_cmd < 0 && rise_a >= 32) begin
                c_cmd    = c;
                cmd_seen = cmd_a;
            end
            if (busy_a && if_a.spi_csn !== 1'b0) csn_bad++;
            if (if_a.wr_en) begin
                if (c_wr < 0) c_wr = c;
                if (n_str < 4) str_a[n_str] = {if_a.wr_addr, if_a.wr_data};
                n_str++;
            end
            if (done_a) c_done = c;
            else begin
                @(negedge clk);
                c++;
            end
        end
        check_eq("cmd_stream", cmd_seen, 32'h03020000);
        check_eq("cmd_len", c_cmd, 63);
        check_eq("first_wr", c_wr, 96);
        check_eq("n_strobes_a", n_str, 4);
        for (int k = 0; k < 4; k++) check_eq("strobe_a", str_a[k], exp_a[k]);
        check_eq("latency_a", c_done, 197);
        check_eq("csn_low_a", csn_bad, 0);
        check_eq("done_state_a", obs_a(), {4'b1000, 8'd4, 16'hFFFF, 2'b01});

        // Start held high: one full load, then an immediate reload from DONE.
        start_a = 1'b1;
        @(negedge clk);
        c = 0; n_str = 0; err = 0; c_done = -1;
        while (c_done < 0 && c < 400) begin
            if (if_a.wr_en) begin
                if (n_str >= 4 || {if_a.wr_addr, if_a.wr_data} !== exp_a[n_str]) err++;
                n_str++;
            end
            if (done_a) c_done = c;
            else begin
                @(negedge clk);
                c++;
            end
        end
        check_eq("held_strobes", n_str, 4);
        check_eq("held_data", err, 0);
        check_eq("held_latency", c_done, 197);
        @(negedge clk);
        check_eq("reload", {busy_a, done_a, if_a.wr_addr}, {1'b1, 1'b0, 8'd0});
        start_a = 1'b0;

        // 256 words, reset during word 2.
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        c = 0; n_str = 0;
        while (n_str < 2 && c < 2000) begin
            if (if_b.wr_en) n_str++;
            @(negedge clk);
            c++;
        end
        check_eq("pre_reset_strobes", n_str, 2);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("midreset_b", obs_b(), RST_VEC);
        n_str = 0;
        repeat (5) begin
            @(negedge clk);
            if (if_b.wr_en) n_str++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (if_b.wr_en) n_str++;
        end
        check_eq("no_strobe_after_reset", n_str, 0);
        check_eq("idle_after_reset", {busy_b, done_b, if_b.spi_csn}, 3'b001);

        // Full 256-word load after the abort.
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        c = 0; n_str = 0; err = 0; c_done = -1; last_addr = '0; first_addr = 8'hAA;
        while (c_done < 0 && c < 9000) begin
            if (if_b.wr_en) begin
                exp16 = {8'(n_str), ~8'(n_str)};
                if (if_b.wr_addr !== 8'(n_str) || if_b.wr_data !== exp16) err++;
                if (n_str == 0) first_addr = if_b.wr_addr;
                last_addr = if_b.wr_addr;
                n_str++;
            end
            if (done_b) c_done = c;
            else begin
                @(negedge clk);
                c++;
            end
        end
        check_eq("restart_addr0", first_addr, 8'h00);
        check_eq("full_strobes", n_str, 256);
        check_eq("full_data", err, 0);
        check_eq("last_addr", last_addr, 8'hFF);
        check_eq("full_latency", c_done, 8513);
        n_str = 0;
        repeat (20) begin
            @(negedge clk);
            if (if_b.wr_en) n_str++;
        end
        check_eq("no_wrap_write", n_str, 0);
        check_eq("done_hold_b", {busy_b, done_b, if_b.spi_csn}, 3'b011);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter WORDS, default 256, meaning the number of 16-bit words copied (1..256).
REQ-002 SHALL have parameter FLASH_ADDR, default 24'h020000, meaning the SPI flash byte offset of the boot image.
REQ-003 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin a load, level-sampled.
REQ-006 SHALL have port spi_sck  output  1  SPI clock, mode 0.
REQ-007 SHALL have port spi_csn  output  1  flash chip select, active-low.
REQ-008 SHALL have port spi_mosi  output  1  serial data to flash, MSB first.
REQ-009 SHALL have port spi_miso  input  1  serial data from flash.
REQ-010 SHALL have port wr_en  output  1  one-cycle write strobe into the instruction memory.
REQ-011 SHALL have port wr_addr  output  8  instruction memory word address.
REQ-012 SHALL have port wr_data  output  16  instruction word, valid while wr_en is high.
REQ-013 SHALL have port busy  output  1  high from the first CMD cycle through the last WRITE cycle.
REQ-014 SHALL have port done  output  1  high after a complete load, until the next accepted start.

Function
REQ-015 SHALL implement the FSM IDLE -> CMD -> DATA -> WRITE -> (DATA | FIN) -> DONE.
REQ-016 SHALL leave IDLE or DONE for CMD on the first posedge where start=1; start in any other state SHALL be ignored.
REQ-017 SHALL drive spi_csn=0 in CMD, DATA and WRITE, and spi_csn=1 in IDLE, FIN and DONE.
REQ-018 SHALL generate spi_sck at clk/2: low phase, then high phase, two clk cycles per bit; spi_sck SHALL be 0 outside CMD and DATA.
REQ-019 SHALL update spi_mosi only while spi_sck is low and sample spi_miso on the clk edge that drives spi_sck high-to-low.
REQ-020 SHALL in CMD shift out 32 bits, 8'h03 followed by FLASH_ADDR[23:0], MSB first, taking exactly 64 clk cycles; spi_mosi SHALL be 0 outside CMD.
REQ-021 SHALL in DATA shift in 16 bits MSB first, the first byte received being wr_data[15:8], taking exactly 32 clk cycles per word.
REQ-022 SHALL spend exactly one cycle in WRITE with wr_en=1, wr_data=the assembled word and wr_addr=the word index; spi_sck SHALL be held low, pausing the flash stream.
REQ-023 SHALL increment wr_addr after each WRITE and go WRITE -> DATA while words remain; after word WORDS-1 it SHALL go WRITE -> FIN.
REQ-024 SHALL make FIN last one cycle, deasserting spi_csn, then enter DONE with done=1 and busy=0.
REQ-025 SHALL give a total load latency of 64 + 33*WORDS + 1 cycles from the first CMD cycle to the first DONE cycle.
REQ-026 SHALL keep wr_en=0 in every state except WRITE, so there is exactly one strobe per word and never more than WORDS strobes per load.
REQ-027 SHALL wrap wr_addr modulo 256 and never write beyond index WORDS-1.
REQ-028 SHALL reset wr_addr to 0 and clear done in the cycle a start from DONE is accepted (reload).
REQ-029 SHALL hold wr_data stable from WRITE until the next WRITE.

Reset
REQ-030 SHALL, while rst_n=0, force the state to IDLE and the outputs to spi_csn=1, spi_sck=0, spi_mosi=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, independent of clk.
REQ-031 SHALL, on reset mid-load, abort with no further wr_en pulse and spi_csn high immediately; a later start SHALL restart from word 0.
REQ-032 SHALL begin operation on the first posedge after rst_n deasserts.

Verification
REQ-033 SHALL verify reset: rst_n=0 -> all outputs at REQ-030 values without any clk edge.
REQ-034 SHALL verify the command: start pulse, WORDS=4 -> the MOSI bit stream equals 32'h03020000, 64 clk cycles in CMD, csn low throughout.
REQ-035 SHALL verify the data path: flash model returns bytes 12 34 AB CD 00 01 FF FF, WORDS=4 -> wr_en strobes at addr 0..3 with data 1234, ABCD, 0001, FFFF; done=1 at cycle 64+132+1=197.
REQ-036 SHALL verify mid-load reset: rst_n low during word 2 of 256 -> no further strobes, csn=1 at once; restart writes from addr 0.
REQ-037 SHALL verify start ignored while busy: start held high throughout -> exactly WORDS strobes, then an immediate reload from DONE with addr back to 0.
REQ-038 SHALL verify full size: WORDS=256 -> the last strobe is at addr 8'hFF with no wrap write; total latency is 8513 cycles.
